gnn_0_example_save_stream: RTL

//  Parametrised save engine: decodes one save instruction, reads N lines from the on-chip

---
 rtl/gnn_0_example_save_pkg.sv | 36 +++
 rtl/gnn_0_example_sync_fifo.sv | 63 ++++++
 rtl/gnn_0_example_save_stream.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/gnn_0_example_save_pkg.sv
// Shared types for the save engine: instruction field map and FSM state encoding.
// The instruction word is decoded field by field from the positions below.
package gnn_0_example_save_pkg;

    localparam int INST_FIELD_WIDTH  = 16;
    localparam int INST_STRIDE_WIDTH = 8;
    localparam int INST_XFER_LSB     = 80;
    localparam int INST_DRAM_LSB     = 64;
    localparam int INST_COUNT_LSB    = 48;
    localparam int INST_START_LSB    = 32;
    localparam int INST_STRIDE_LSB   = 24;

    typedef struct packed {
        logic [INST_FIELD_WIDTH-1:0]  xfer_bytes;
        logic [INST_FIELD_WIDTH-1:0]  dram_addr;
        logic [INST_FIELD_WIDTH-1:0]  line_count;
        logic [INST_FIELD_WIDTH-1:0]  buf_start;
        logic [INST_STRIDE_WIDTH-1:0] stride;
    } save_inst_t;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        STREAM,
        WAIT_WR,
        DONE
    } save_state_e;

    // A zero stride would re-read one line forever, so it is promoted to 1.
    function automatic logic [INST_STRIDE_WIDTH-1:0] effective_stride(
        input logic [INST_STRIDE_WIDTH-1:0] stride
    );
        return (stride == '0) ? INST_STRIDE_WIDTH'(1) : stride;
    endfunction

endpackage

// File: rtl/gnn_0_example_sync_fifo.sv
// First-word-fall-through skid FIFO between the feature-buffer read port and the
// output stream; the head word is visible whenever the FIFO is not empty.
module gnn_0_example_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 512
) (
    input  logic                       aclk,
    input  logic                       areset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    no_overflow: assert property (@(posedge aclk) disable iff (!areset_n) !(push && full && !pop));

endmodule

// File: rtl/gnn_0_example_save_stream.sv
// Save engine: decodes one save instruction, reads feature-buffer lines under a read-credit
// limit, streams them over AXI-Stream and hands the DRAM address/size to the write master.
module gnn_0_example_save_stream
    import gnn_0_example_save_pkg::*;
#(
    parameter int SAVE_INST_LENGTH   = 96,
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int C_XFER_SIZE_WIDTH  = 32,
    parameter int C_BUF_ADDR_WIDTH   = 11,
    parameter int C_FIFO_DEPTH       = 8
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic                          ap_start,
    output logic                          ap_done,
    output logic                          ap_idle,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] ctrl_addr_offset,
    input  logic [SAVE_INST_LENGTH-1:0]   ctrl_instruction,
    output logic                          buf_rd_addr_valid,
    output logic [C_BUF_ADDR_WIDTH-1:0]   buf_rd_addr,
    input  logic                          buf_rd_data_valid,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] buf_rd_data,
    output logic                          wr_ctrl_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] wr_ctrl_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0]  wr_ctrl_xfer_size,
    input  logic                          wr_ctrl_done,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] m_axis_tdata
);

    localparam int CNT_W = $clog2(C_FIFO_DEPTH) + 1;
    localparam int SUM_W = CNT_W + 1;

    save_state_e                  state;
    save_state_e                  state_next;
    save_inst_t                   inst_dec;
    logic [INST_FIELD_WIDTH-1:0]  lines_left;
    logic [C_BUF_ADDR_WIDTH-1:0]  rd_addr;
    logic [INST_STRIDE_WIDTH-1:0] stride_q;
    logic [CNT_W-1:0]             inflight;
    logic [CNT_W-1:0]             fifo_count;
    logic [SUM_W-1:0]             credit_used;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         wr_done_seen;
    logic                         accept;
    logic                         issue;
    logic                         push;
    logic                         pop;
    logic                         unused_bits;

    assign inst_dec.xfer_bytes = ctrl_instruction[INST_XFER_LSB   +: INST_FIELD_WIDTH];
    assign inst_dec.dram_addr  = ctrl_instruction[INST_DRAM_LSB   +: INST_FIELD_WIDTH];
    assign inst_dec.line_count = ctrl_instruction[INST_COUNT_LSB  +: INST_FIELD_WIDTH];
    assign inst_dec.buf_start  = ctrl_instruction[INST_START_LSB  +: INST_FIELD_WIDTH];
    assign inst_dec.stride     = ctrl_instruction[INST_STRIDE_LSB +: INST_STRIDE_WIDTH];
    assign unused_bits         = ^{ctrl_instruction, fifo_full};

    // Every read in flight owns a FIFO slot, so a return can never find the FIFO full.
    assign credit_used = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign accept      = (state == IDLE) && ap_start;
    assign issue       = (state == STREAM) && (lines_left != '0) &&
                         (credit_used < SUM_W'(C_FIFO_DEPTH));
    // Returns with nothing outstanding belong to a request cut off by reset and are dropped.
    assign push        = buf_rd_data_valid && (inflight != '0);
    assign pop         = m_axis_tvalid && m_axis_tready;

    assign buf_rd_addr_valid = issue;
    assign buf_rd_addr       = rd_addr;
    assign m_axis_tvalid     = !fifo_empty;

    gnn_0_example_sync_fifo #(
        .DEPTH (C_FIFO_DEPTH),
        .WIDTH (C_M_AXI_DATA_WIDTH)
    ) u_fifo (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .push      (push),
        .push_data (buf_rd_data),
        .pop       (pop),
        .head      (m_axis_tdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        ap_idle       = 1'b0;
        ap_done       = 1'b0;
        wr_ctrl_start = 1'b0;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_next = (inst_dec.line_count == '0) ? DONE : LAUNCH;
                end
            end
            LAUNCH: begin
                wr_ctrl_start = 1'b1;
                state_next    = STREAM;
            end
            STREAM: begin
                if ((lines_left == '0) && (inflight == '0) && fifo_empty) begin
                    state_next = WAIT_WR;
                end
            end
            WAIT_WR: begin
                if (wr_done_seen || wr_ctrl_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ap_done    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address generator: start + k*stride, advanced by one stride per issued read.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            lines_left <= '0;
            rd_addr    <= '0;
            stride_q   <= '0;
        end else if (accept) begin
            lines_left <= inst_dec.line_count;
            rd_addr    <= C_BUF_ADDR_WIDTH'(inst_dec.buf_start);
            stride_q   <= effective_stride(inst_dec.stride);
        end else if (issue) begin
            lines_left <= lines_left - INST_FIELD_WIDTH'(1);
            rd_addr    <= rd_addr + C_BUF_ADDR_WIDTH'(stride_q);
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            inflight <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // The write master may finish before the last beat drains; remember that completion.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_done_seen <= 1'b0;
        end else if ((state == IDLE) || (state == DONE)) begin
            wr_done_seen <= 1'b0;
        end else if (wr_ctrl_done) begin
            wr_done_seen <= 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ctrl_addr_offset <= '0;
            wr_ctrl_xfer_size   <= '0;
        end else if (accept && (inst_dec.line_count != '0)) begin
            wr_ctrl_addr_offset <= ctrl_addr_offset + C_M_AXI_ADDR_WIDTH'(inst_dec.dram_addr);
            wr_ctrl_xfer_size   <= C_XFER_SIZE_WIDTH'(inst_dec.xfer_bytes);
        end else if (state == DONE) begin
            wr_ctrl_addr_offset <= '0;
            wr_ctrl_xfer_size   <= '0;
        end
    end

endmodule
